// File: rtl/m_shift_add_mul.sv
// Iterative 32x32 -> 64-bit RV32M multiplier: one operand bit per cycle through a
// shared 64-bit carry-select adder, with a start/done handshake toward writeback.

module m_adder (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] sum
);
  localparam int BW = 8;
  localparam int NB = 64 / BW;

  logic [NB-1:0] carry;
  assign carry[0] = c_in;

  // Each byte lane precomputes both carry-in outcomes; the incoming carry selects one
  for (genvar gi = 0; gi < NB; gi++) begin : g_blk
    if (gi < NB - 1) begin : g_mid
      logic [BW:0] s0, s1;
      assign s0 = {1'b0, a[gi*BW +: BW]} + {1'b0, b[gi*BW +: BW]};
      assign s1 = s0 + {{BW{1'b0}}, 1'b1};
      assign sum[gi*BW +: BW] = carry[gi] ? s1[BW-1:0] : s0[BW-1:0];
      assign carry[gi+1] = carry[gi] ? s1[BW] : s0[BW];
    end else begin : g_last
      logic [BW-1:0] s0, s1;
      assign s0 = a[gi*BW +: BW] + b[gi*BW +: BW];
      assign s1 = s0 + {{(BW-1){1'b0}}, 1'b1};
      assign sum[gi*BW +: BW] = carry[gi] ? s1 : s0;
    end
  end
endmodule

module m_shift_add_mul (
  input  logic        i_clk_1,
  input  logic        i_rst_1,
  input  logic        i_start_1,
  input  logic [1:0]  i_opSigned_2,
  input  logic [31:0] i_mulOperand1_32,
  input  logic [31:0] i_mulOperand2_32,
  output logic        o_busy_1,
  output logic        o_done_1,
  output logic [63:0] o_product_64
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] mcand, acc;
  logic [31:0] mplr;
  logic [4:0]  cnt;
  logic        neg;

  logic [63:0] add_a, add_b, add_sum;
  logic        add_cin;

  logic        neg1, neg2;
  logic [31:0] mag1, mag2;

  // Two's-complement negation maps 0x80000000 onto itself, which is the correct unsigned magnitude
  assign neg1 = i_opSigned_2[1] & i_mulOperand1_32[31];
  assign neg2 = i_opSigned_2[0] & i_mulOperand2_32[31];
  assign mag1 = neg1 ? -i_mulOperand1_32 : i_mulOperand1_32;
  assign mag2 = neg2 ? -i_mulOperand2_32 : i_mulOperand2_32;

  m_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .c_in (add_cin),
    .sum  (add_sum)
  );

  always_comb begin
    state_next = state;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state)
      IDLE: if (i_start_1) state_next = RUN;
      RUN: begin
        add_a = acc;
        add_b = mplr[0] ? mcand : '0;
        if (cnt == 5'd31) state_next = FIX;
      end
      FIX: begin
        // ~acc + 1 negates the magnitude; only consumed when the result is negative
        add_a      = ~acc;
        add_cin    = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_1 or posedge i_rst_1) begin
    if (i_rst_1) begin
      state        <= IDLE;
      mcand        <= '0;
      mplr         <= '0;
      acc          <= '0;
      cnt          <= '0;
      neg          <= 1'b0;
      o_product_64 <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (i_start_1) begin
          mcand <= {32'd0, mag1};
          mplr  <= mag2;
          acc   <= '0;
          cnt   <= '0;
          neg   <= neg1 ^ neg2;
        end
        RUN: begin
          acc   <= add_sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 5'd1;
        end
        FIX: begin
          if (neg) begin
            acc          <= add_sum;
            o_product_64 <= add_sum;
          end else begin
            o_product_64 <= acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy_1 = (state == RUN) || (state == FIX);
  assign o_done_1 = (state == DONE);
endmodule

// File: tb/tb_m_shift_add_mul.sv
// Self-checking bench for m_shift_add_mul: directed and random products against a
// wide-integer reference, plus handshake, held-start and asynchronous-reset scenarios.

module tb_m_shift_add_mul;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  sgn;
  logic [31:0] op1, op2;
  logic        busy, done;
  logic [63:0] product;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  m_shift_add_mul dut (
    .i_clk_1          (clk),
    .i_rst_1          (rst),
    .i_start_1        (start),
    .i_opSigned_2     (sgn),
    .i_mulOperand1_32 (op1),
    .i_mulOperand2_32 (op2),
    .o_busy_1         (busy),
    .o_done_1         (done),
    .o_product_64     (product)
  );

  // Reference: extend each operand per its signedness, multiply exactly, keep 64 bits
  function automatic logic [63:0] ref_mul(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ea, eb, p;
    ea = s[1] ? {{34{a[31]}}, a} : {34'd0, a};
    eb = s[0] ? {{34{b[31]}}, b} : {34'd0, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb);
    logic [63:0] expv;
    int cyc, busy_cnt;
    expv = ref_mul(s, a, b);
    @(negedge clk);
    sgn = s; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; busy_cnt = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (disturb && cyc == 5) begin
        start = 1'b1; op1 = $urandom; op2 = $urandom; sgn = 2'($urandom);
      end else if (disturb && cyc == 6) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 cyc++;
    end
    check({tag, " done_latency"}, 64'(cyc), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " product"}, product, expv);
    $display("op %s sgn=%b a=%h b=%h product=%h expected=%h", tag, s, a, b, product, expv);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check({tag, " done_single"}, {63'd0, done}, 64'd0);
      check({tag, " product_hold"}, product, expv);
    end
    check({tag, " idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] expv;
    int q[$];
    int second;

    rst = 1'b1; start = 1'b0; sgn = 2'b00; op1 = '0; op2 = '0;
    #1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset product", product, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("mulhu_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("mulhu_ff const", product, 64'hFFFFFFFE00000001);
    run_op("mulh_m1", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("mulh_m1 const", product, 64'h0000000000000001);
    run_op("mulh_min", 2'b11, 32'h80000000, 32'h80000000, 1'b0);
    check("mulh_min const", product, 64'h4000000000000000);
    run_op("mulhsu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("mulhsu_ff const", product, 64'hFFFFFFFF00000001);
    run_op("mulhsu_min", 2'b10, 32'h80000000, 32'h00000002, 1'b0);
    check("mulhsu_min const", product, 64'hFFFFFFFF00000000);
    run_op("mulh_zero", 2'b11, 32'hFFFFFFF9, 32'h00000000, 1'b0);
    check("mulh_zero const", product, 64'h0);
    run_op("mulh_7xm3", 2'b11, 32'h00000007, 32'hFFFFFFFD, 1'b0);
    check("mulh_7xm3 const", product, 64'hFFFFFFFFFFFFFFEB);
    run_op("disturb", 2'b11, 32'h00001234, 32'hFFFF0001, 1'b1);

    for (int i = 0; i < 8; i++)
      run_op("random", 2'($urandom), $urandom, $urandom, 1'b0);

    // Start held high: one capture now, the next only after the DONE cycle
    expv = ref_mul(2'b11, 32'hDEADBEEF, 32'h01234567);
    @(negedge clk);
    sgn = 2'b11; op1 = 32'hDEADBEEF; op2 = 32'h01234567; start = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) q.push_back(c);
    end
    start = 1'b0;
    second = (q.size() > 1) ? q[1] : -1;
    check("held pulses", 64'(q.size()), 64'd2);
    check("held first", (q.size() > 0) ? 64'(q[0]) : 64'hFFFF, 64'd33);
    check("held second", 64'(second), 64'd68);
    check("held product", product, expv);
    $display("op held_start sgn=11 a=deadbeef b=01234567 product=%h pulses=%0d", product, q.size());
    repeat (3) @(posedge clk);

    // Asynchronous reset in the middle of an operation
    run_op("pre_rst", 2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    @(negedge clk);
    sgn = 2'b00; op1 = 32'h0000FFFF; op2 = 32'h0000FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst busy", {63'd0, busy}, 64'd0);
    check("async_rst done", {63'd0, done}, 64'd0);
    check("async_rst product", product, 64'd0);
    $display("op async_reset busy=%b done=%b product=%h", busy, done, product);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst idle", {62'd0, busy, done}, 64'd0);
    run_op("rst_3x5", 2'b00, 32'd3, 32'd5, 1'b0);
    check("rst_3x5 const", product, 64'h000000000000000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
